// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal sync tree nodes: field widths, node FSM states
// and the per-child pending request entry.
package fractal_sync_pkg;

  // Field widths mirror the tile-level fsync decoder widths.
  localparam int unsigned FSYNC_AGGR_W         = 8;
  localparam int unsigned FSYNC_ID_W           = 8;
  localparam int unsigned FSYNC_SRC_W          = 2;
  localparam int unsigned FSYNC_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    NODE_IDLE,
    NODE_PARTIAL,
    NODE_RESOLVE,
    NODE_FWD,
    NODE_WAIT_UP,
    NODE_WAKE
  } node_state_e;

  typedef struct packed {
    logic                    valid;
    logic [FSYNC_AGGR_W-1:0] aggr;
    logic [FSYNC_ID_W-1:0]   id;
  } pend_entry_t;

endpackage

// File: rtl/fractal_sync_if.sv
// Fsync link between a requester (mst_port) and a tree node (slv_port):
// sync/aggr/id/src travel upward, wake/error travel back down.
interface fractal_sync_if
  import fractal_sync_pkg::*;
#(
  parameter int unsigned AGGR_W = FSYNC_AGGR_W,
  parameter int unsigned ID_W   = FSYNC_ID_W
);
  logic                   sync;
  logic [AGGR_W-1:0]      aggr;
  logic [ID_W-1:0]        id;
  logic [FSYNC_SRC_W-1:0] src;
  logic                   wake;
  logic                   error;

  modport mst_port (output sync, aggr, id, src, input  wake, error);
  modport slv_port (input  sync, aggr, id, src, output wake, error);
endinterface

// File: rtl/fractal_sync_node_port.sv
// One child-facing port of a pair node: holds the pending request, flags
// repeated syncs, and registers the wake/error returned to the child.
module fractal_sync_node_port
  import fractal_sync_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  node_state_e             state_q,
  input  logic                    wake_cmd,
  input  logic                    err_cmd,
  fractal_sync_if.slv_port        ch_if,
  output logic                    accept,
  output pend_entry_t             entry_q
);

  logic dbl_sync;
  logic wake_q;
  logic error_q;
  logic unused_src;

  // A sync is taken only when nothing is pending and the barrier is not
  // releasing; anything else is a protocol error for this child.
  assign accept     = ch_if.sync & ~entry_q.valid & (state_q != NODE_WAKE);
  assign dbl_sync   = ch_if.sync & ~accept;
  assign unused_src = ^ch_if.src;

  // NOTE: non-blocking assignments on all state so every register in this
  // block sees pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_q <= '0;
      wake_q  <= 1'b0;
      error_q <= 1'b0;
    end else if (clear_i) begin
      entry_q <= '0;
      wake_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      // Only children with a live request are woken (matters on timeout).
      wake_q  <= wake_cmd & entry_q.valid;
      error_q <= (wake_cmd & err_cmd & entry_q.valid) | dbl_sync;
      if (state_q == NODE_WAKE) begin
        entry_q <= '0;
      end else if (accept) begin
        entry_q <= '{valid: 1'b1,
                     aggr:  FSYNC_AGGR_W'(ch_if.aggr),
                     id:    FSYNC_ID_W'(ch_if.id)};
      end
    end
  end

  assign ch_if.wake  = wake_q;
  assign ch_if.error = error_q;

endmodule

// File: rtl/fractal_sync_pair_node.sv
// Level-1 fractal sync node: merges one request from each of two children and
// terminates locally or forwards upward. Optional FRACTAL_SYNC_NODE_TIMEOUT_EN.
module fractal_sync_pair_node
  import fractal_sync_pkg::*;
#(
  parameter int unsigned AGGR_W         = FSYNC_AGGR_W,
  parameter int unsigned ID_W           = FSYNC_ID_W,
  parameter int unsigned TIMEOUT_CYCLES = FSYNC_TIMEOUT_CYCLES
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  fractal_sync_if.slv_port ch0_fsync_if_i,
  fractal_sync_if.slv_port ch1_fsync_if_i,
  fractal_sync_if.mst_port up_fsync_if_o
);

  node_state_e       state_q, state_d;
  logic              wake_err_d;
  logic              acc0, acc1;
  pend_entry_t       entry0, entry1;
  logic              timeout;
  logic              mismatch;
  logic              wake_cmd, err_cmd;
  logic              up_sync_d, up_sync_q;
  logic [AGGR_W-1:0] up_aggr_d, up_aggr_q;
  logic [ID_W-1:0]   up_id_d, up_id_q;

  fractal_sync_node_port u_port0 (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (clear_i),
    .state_q  (state_q),
    .wake_cmd (wake_cmd),
    .err_cmd  (err_cmd),
    .ch_if    (ch0_fsync_if_i),
    .accept   (acc0),
    .entry_q  (entry0)
  );

  fractal_sync_node_port u_port1 (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (clear_i),
    .state_q  (state_q),
    .wake_cmd (wake_cmd),
    .err_cmd  (err_cmd),
    .ch_if    (ch1_fsync_if_i),
    .accept   (acc1),
    .entry_q  (entry1)
  );

  assign mismatch = (entry0.aggr != entry1.aggr) || (entry0.id != entry1.id);

`ifdef FRACTAL_SYNC_NODE_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] tmo_cnt_q;

  // Restarts on every state change so each waiting state gets a full budget.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
    end else if (clear_i || (state_d != state_q) ||
                 !(state_q inside {NODE_PARTIAL, NODE_WAIT_UP})) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign timeout = (state_q inside {NODE_PARTIAL, NODE_WAIT_UP}) &&
                   (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= NODE_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: defaults first so every path assigns state_d and wake_err_d;
  // a missing branch would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    wake_err_d = 1'b0;
    unique case (state_q)
      NODE_IDLE: begin
        if (acc0 && acc1)      state_d = NODE_RESOLVE;
        else if (acc0 || acc1) state_d = NODE_PARTIAL;
      end
      NODE_PARTIAL: begin
        if ((acc0 && entry1.valid) || (acc1 && entry0.valid)) begin
          state_d = NODE_RESOLVE;
        end else if (timeout) begin
          state_d    = NODE_WAKE;
          wake_err_d = 1'b1;
        end
      end
      NODE_RESOLVE: begin
        if (mismatch) begin
          state_d    = NODE_WAKE;
          wake_err_d = 1'b1;
        end else if (entry0.aggr[0]) begin
          state_d = NODE_WAKE;
        end else begin
          state_d = NODE_FWD;
        end
      end
      NODE_FWD: state_d = NODE_WAIT_UP;
      NODE_WAIT_UP: begin
        if (up_fsync_if_o.wake || up_fsync_if_o.error) begin
          state_d    = NODE_WAKE;
          wake_err_d = up_fsync_if_o.error;
        end else if (timeout) begin
          state_d    = NODE_WAKE;
          wake_err_d = 1'b1;
        end
      end
      NODE_WAKE: state_d = NODE_IDLE;
      default:   state_d = NODE_IDLE;
    endcase
    if (clear_i) begin
      state_d    = NODE_IDLE;
      wake_err_d = 1'b0;
    end
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with the state they belong to.
  always_comb begin
    wake_cmd  = (state_d == NODE_WAKE);
    err_cmd   = wake_err_d;
    up_sync_d = (state_d == NODE_FWD);
    up_aggr_d = '0;
    up_id_d   = '0;
    if (up_sync_d) begin
      up_aggr_d = AGGR_W'(entry0.aggr >> 1);
      up_id_d   = ID_W'(entry0.id >> 1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      up_sync_q <= 1'b0;
      up_aggr_q <= '0;
      up_id_q   <= '0;
    end else begin
      up_sync_q <= up_sync_d;
      up_aggr_q <= up_aggr_d;
      up_id_q   <= up_id_d;
    end
  end

  assign up_fsync_if_o.sync = up_sync_q;
  assign up_fsync_if_o.aggr = up_aggr_q;
  assign up_fsync_if_o.id   = up_id_q;
  assign up_fsync_if_o.src  = '0;

endmodule

// File: tb/tb_fractal_sync_pair_node.sv
// Scoreboard bench for fractal_sync_pair_node: directed stimulus pushes the
// expected output events, a negedge monitor pops and compares them.
module tb_fractal_sync_pair_node;
  import fractal_sync_pkg::*;

  localparam int unsigned AW = FSYNC_AGGR_W;
  localparam int unsigned IW = FSYNC_ID_W;
`ifdef FRACTAL_SYNC_NODE_TIMEOUT_EN
  localparam int unsigned TMO        = 8;
  localparam int          T2_UP_EDGE = 12;
`else
  localparam int unsigned TMO        = FSYNC_TIMEOUT_CYCLES;
  localparam int          T2_UP_EDGE = 20;
`endif

  typedef struct {
    int          cyc;
    logic [63:0] bits;
  } ev_t;

  logic clk_i   = 1'b0;
  logic rst_ni  = 1'b0;
  logic clear_i = 1'b0;
  int   edge_cnt = 0;
  int   b = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  exp_q[$];

  fractal_sync_if #(.AGGR_W(AW), .ID_W(IW)) ch0_if ();
  fractal_sync_if #(.AGGR_W(AW), .ID_W(IW)) ch1_if ();
  fractal_sync_if #(.AGGR_W(AW), .ID_W(IW)) up_if ();

  fractal_sync_pair_node #(
    .AGGR_W         (AW),
    .ID_W           (IW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .ch0_fsync_if_i (ch0_if),
    .ch1_fsync_if_i (ch1_if),
    .up_fsync_if_o  (up_if)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack_ev(logic [FSYNC_SRC_W-1:0] src, logic w0, logic e0,
                                          logic w1, logic e1, logic us,
                                          logic [AW-1:0] ua, logic [IW-1:0] ui);
    return 64'({src, w0, e0, w1, e1, us, ua, ui});
  endfunction

  // Expected event visible in cycle b+rel (sampled just after edge b+rel-1).
  task automatic expect_ev(input int rel, input logic w0, input logic e0, input logic w1,
                           input logic e1, input logic us, input logic [AW-1:0] ua,
                           input logic [IW-1:0] ui);
    ev_t e;
    e.cyc  = b + rel;
    e.bits = pack_ev('0, w0, e0, w1, e1, us, ua, ui);
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    ch0_if.sync = 1'b0; ch0_if.aggr = '0; ch0_if.id = '0; ch0_if.src = '0;
    ch1_if.sync = 1'b0; ch1_if.aggr = '0; ch1_if.id = '0; ch1_if.src = '0;
    up_if.wake  = 1'b0; up_if.error = 1'b0;
    clear_i     = 1'b0;
  endtask

  // Park at the negedge preceding edge b+rel; inputs set now are sampled there.
  task automatic go(input int rel);
    while (edge_cnt < b + rel - 1) @(negedge clk_i);
  endtask

  task automatic step();
    @(negedge clk_i);
    idle_inputs();
  endtask

  task automatic sync0(input logic [AW-1:0] a, input logic [IW-1:0] i);
    ch0_if.sync = 1'b1; ch0_if.aggr = a; ch0_if.id = i;
  endtask

  task automatic sync1(input logic [AW-1:0] a, input logic [IW-1:0] i);
    ch1_if.sync = 1'b1; ch1_if.aggr = a; ch1_if.id = i;
  endtask

  task automatic start_test();
    @(negedge clk_i);
    b = edge_cnt;
  endtask

  task automatic end_test(input string name);
    repeat (20) @(negedge clk_i);
    check({name, "_pending_expectations"}, 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk_i) begin
    if (rst_ni) begin
      logic [63:0] act_bits;
      ev_t         e;
      act_bits = pack_ev(up_if.src, ch0_if.wake, ch0_if.error, ch1_if.wake, ch1_if.error,
                         up_if.sync, up_if.aggr, up_if.id);
      if (ch0_if.wake || ch0_if.error || ch1_if.wake || ch1_if.error || up_if.sync) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", act_bits, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("event_cycle", 64'(edge_cnt + 1), 64'(e.cyc));
          check("event_value", act_bits, e.bits);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    #12;
    check("rst_ch0_wake",  64'(ch0_if.wake),  64'd0);
    check("rst_ch0_error", 64'(ch0_if.error), 64'd0);
    check("rst_ch1_wake",  64'(ch1_if.wake),  64'd0);
    check("rst_ch1_error", 64'(ch1_if.error), 64'd0);
    check("rst_up_sync",   64'(up_if.sync),   64'd0);
    check("rst_up_aggr",   64'(up_if.aggr),   64'd0);
    check("rst_up_id",     64'(up_if.id),     64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Local terminate after staggered arrivals.
    start_test();
    go(10); sync0(8'd1, 8'd4); step();
    expect_ev(16, 1, 0, 1, 0, 0, '0, '0);
    go(14); sync1(8'd1, 8'd4); step();
    end_test("local_term");

    // Simultaneous arrival, forward, parent wake.
    start_test();
    expect_ev(7, 0, 0, 0, 0, 1, 8'd3, 8'd1);
    go(5); sync0(8'd6, 8'd2); sync1(8'd6, 8'd2); step();
    expect_ev(T2_UP_EDGE + 1, 1, 0, 1, 0, 0, '0, '0);
    go(T2_UP_EDGE); up_if.wake = 1'b1; step();
    end_test("forward");

    // id mismatch.
    start_test();
    go(3); sync0(8'd2, 8'd8); step();
    expect_ev(8, 1, 1, 1, 1, 0, '0, '0);
    go(6); sync1(8'd2, 8'd10); step();
    end_test("mismatch");

    // Double sync on ch0; original request must survive.
    start_test();
    go(3); sync0(8'd1, 8'd5); step();
    expect_ev(7, 0, 1, 0, 0, 0, '0, '0);
    go(6); sync0(8'd3, 8'd7); step();
    expect_ev(11, 1, 0, 1, 0, 0, '0, '0);
    go(9); sync1(8'd1, 8'd5); step();
    end_test("double_sync");

    // Clear while waiting on the parent; later parent wake ignored.
    start_test();
    expect_ev(7, 0, 0, 0, 0, 1, 8'd3, 8'd1);
    go(5); sync0(8'd6, 8'd2); sync1(8'd6, 8'd2); step();
    go(12); clear_i = 1'b1; step();
    go(15); up_if.wake = 1'b1; step();
    expect_ev(22, 1, 0, 1, 0, 0, '0, '0);
    go(20); sync0(8'd1, 8'd0); sync1(8'd1, 8'd0); step();
    end_test("clear");

    // Sync during WAKE is dropped with error; stray parent responses ignored.
    start_test();
    expect_ev(4, 1, 0, 1, 0, 0, '0, '0);
    go(2); sync0(8'd1, 8'd3); sync1(8'd1, 8'd3); step();
    expect_ev(5, 0, 1, 0, 0, 0, '0, '0);
    go(4); sync0(8'd1, 8'd3); up_if.wake = 1'b1; step();
    go(8); sync1(8'd1, 8'd3); step();
    go(9); up_if.error = 1'b1; step();
    expect_ev(12, 1, 0, 1, 0, 0, '0, '0);
    go(10); sync0(8'd1, 8'd3); step();
    end_test("wake_cycle_sync");

    // Forward with MSB zero-fill, parent answers with error.
    start_test();
    expect_ev(4, 0, 0, 0, 0, 1, 8'h7F, 8'h7F);
    go(2); sync0(8'hFE, 8'hFF); sync1(8'hFE, 8'hFF); step();
    expect_ev(9, 1, 1, 1, 1, 0, '0, '0);
    go(8); up_if.error = 1'b1; step();
    end_test("up_error");

`ifdef FRACTAL_SYNC_NODE_TIMEOUT_EN
    // Only ch1 arrives; timeout wakes ch1 alone with error.
    start_test();
    expect_ev(11, 0, 0, 1, 1, 0, '0, '0);
    go(2); sync1(8'd1, 8'd1); step();
    end_test("timeout");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
